// File: rtl/game_pkg.sv
// Package for the penalty-shootout sequencer.
// Holds the screen/phase and mode enums shared with the draw/vga stages,
// and the default number of regulation shots per side.
package game_pkg;

    typedef enum logic [2:0] {
        START   = 3'd0,
        SHOOTER = 3'd1,
        KEEPER  = 3'd2,
        WINNER  = 3'd3,
        LOOSER  = 3'd4
    } g_state;

    typedef enum logic [0:0] {
        SOLO  = 1'b0,
        MULTI = 1'b1
    } g_mode;

    localparam int SHOOT_ROUNDS = 5;

endpackage

// File: rtl/game_fsm_edge_detect.sv
// Rising-edge detector, reusable for button and mouse-click inputs.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   sig_i     - level input
//   pulse_o   - one-cycle pulse where sig_i is high and was low last cycle
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q, sig_d;

    always_comb begin
        sig_d = sig_i;
    end

    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_d;
    end

    assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/game_fsm.sv
// Penalty-shootout sequencer. Drives game_state/game_mode from the start
// button and resolved shots, keeps goal and round counts, and decides the
// winner once the result can no longer change.
// Ports:
//   clk, rst      - pixel clock, synchronous active-high reset
//   start_btn     - start/confirm button level (rising edge acts)
//   mode_multi    - mode select sampled on the start edge
//   shot_valid    - one-cycle pulse, shot resolved; shot_goal qualifies it
//   game_state    - current screen/phase
//   game_mode     - mode latched at game start
//   player_score  - goals by the player as shooter (saturating)
//   cpu_score     - goals by the opponent (saturating)
//   round_ctr     - completed shot pairs, saturates at 15
//   sudden_death  - set once regulation finished level
module game_fsm
    import game_pkg::*;
#(
    parameter int ROUNDS      = SHOOT_ROUNDS,
    parameter int SCORE_W     = 6,
    parameter int HOLD_CYCLES = 65000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               mode_multi,
    input  logic               shot_valid,
    input  logic               shot_goal,
    output g_state             game_state,
    output g_mode              game_mode,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] cpu_score,
    output logic [3:0]         round_ctr,
    output logic               sudden_death
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    typedef logic [SCORE_W:0] wide_t;

    g_state              state_q, state_d;
    g_mode               mode_q, mode_d;
    logic [SCORE_W-1:0]  player_q, player_d, cpu_q, cpu_d;
    logic [3:0]          round_q, round_d, p_shots_q, p_shots_d;
    logic                sd_q, sd_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic                start_edge;

    // Candidate post-shot values, used by whichever of SHOOTER/KEEPER acts.
    logic [SCORE_W-1:0]  player_inc, cpu_inc;
    logic [3:0]          p_shots_inc, round_inc;
    logic                p_ahead_s, c_ahead_s, p_ahead_k, c_ahead_k;

    edge_detect u_start_edge (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (start_btn),
        .pulse_o (start_edge)
    );

    always_comb begin
        player_inc  = (shot_goal && player_q != '1) ? player_q + SCORE_W'(1) : player_q;
        cpu_inc     = (shot_goal && cpu_q != '1)    ? cpu_q + SCORE_W'(1)    : cpu_q;
        p_shots_inc = (p_shots_q != 4'hf) ? p_shots_q + 4'd1 : p_shots_q;
        round_inc   = (round_q != 4'hf)   ? round_q + 4'd1   : round_q;

        // Regulation verdict: a side wins once the other cannot catch up even
        // by scoring every remaining shot. Shot counts never exceed ROUNDS
        // while in regulation, so the remaining-shot subtraction cannot wrap.
        p_ahead_s = wide_t'(player_inc) > wide_t'(cpu_q) + (wide_t'(ROUNDS) - wide_t'(round_q));
        c_ahead_s = wide_t'(cpu_q) > wide_t'(player_inc) + (wide_t'(ROUNDS) - wide_t'(p_shots_inc));
        p_ahead_k = wide_t'(player_q) > wide_t'(cpu_inc) + (wide_t'(ROUNDS) - wide_t'(round_inc));
        c_ahead_k = wide_t'(cpu_inc) > wide_t'(player_q) + (wide_t'(ROUNDS) - wide_t'(p_shots_q));
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        player_d  = player_q;
        cpu_d     = cpu_q;
        round_d   = round_q;
        p_shots_d = p_shots_q;
        sd_d      = sd_q;
        hold_d    = hold_q;

        case (state_q)
            START: begin
                if (start_edge) begin
                    state_d   = SHOOTER;
                    mode_d    = mode_multi ? MULTI : SOLO;
                    player_d  = '0;
                    cpu_d     = '0;
                    round_d   = '0;
                    p_shots_d = '0;
                    sd_d      = 1'b0;
                end
            end
            SHOOTER: begin
                if (shot_valid) begin
                    player_d  = player_inc;
                    p_shots_d = p_shots_inc;
                    hold_d    = '0;
                    // Sudden death only decides after the keeper completes the pair.
                    if (!sd_q && p_ahead_s)      state_d = WINNER;
                    else if (!sd_q && c_ahead_s) state_d = LOOSER;
                    else                         state_d = KEEPER;
                end
            end
            KEEPER: begin
                if (shot_valid) begin
                    cpu_d   = cpu_inc;
                    round_d = round_inc;
                    hold_d  = '0;
                    if (sd_q) begin
                        if (player_q > cpu_inc)      state_d = WINNER;
                        else if (cpu_inc > player_q) state_d = LOOSER;
                        else                         state_d = SHOOTER;
                    end else if (p_ahead_k) begin
                        state_d = WINNER;
                    end else if (c_ahead_k) begin
                        state_d = LOOSER;
                    end else begin
                        state_d = SHOOTER;
                        // Undecided after the last regulation pair means level.
                        if (round_inc >= 4'(ROUNDS)) sd_d = 1'b1;
                    end
                end
            end
            WINNER, LOOSER: begin
                if (hold_q < HOLD_W'(HOLD_CYCLES)) hold_d = hold_q + HOLD_W'(1);
                else if (start_edge)               state_d = START;
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= START;
            mode_q    <= SOLO;
            player_q  <= '0;
            cpu_q     <= '0;
            round_q   <= '0;
            p_shots_q <= '0;
            sd_q      <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            player_q  <= player_d;
            cpu_q     <= cpu_d;
            round_q   <= round_d;
            p_shots_q <= p_shots_d;
            sd_q      <= sd_d;
            hold_q    <= hold_d;
        end
    end

    assign game_state   = state_q;
    assign game_mode    = mode_q;
    assign player_score = player_q;
    assign cpu_score    = cpu_q;
    assign round_ctr    = round_q;
    assign sudden_death = sd_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with a short hold time.
module tb_game_fsm;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       mode_multi = 1'b0;
    logic       shot_valid = 1'b0;
    logic       shot_goal = 1'b0;
    g_state     game_state;
    g_mode      game_mode;
    logic [5:0] player_score, cpu_score;
    logic [3:0] round_ctr;
    logic       sudden_death;

    int n_checks = 0;
    int n_fail   = 0;

    game_fsm #(.ROUNDS(5), .SCORE_W(6), .HOLD_CYCLES(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .mode_multi   (mode_multi),
        .shot_valid   (shot_valid),
        .shot_goal    (shot_goal),
        .game_state   (game_state),
        .game_mode    (game_mode),
        .player_score (player_score),
        .cpu_score    (cpu_score),
        .round_ctr    (round_ctr),
        .sudden_death (sudden_death)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shot(input logic goal);
        shot_valid = 1'b1;
        shot_goal  = goal;
        tick();
        shot_valid = 1'b0;
        shot_goal  = 1'b0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int p, input int c,
                             input int r, input int sd);
        check({tag, "_state"}, int'(game_state), st);
        check({tag, "_pscore"}, int'(player_score), p);
        check({tag, "_cscore"}, int'(cpu_score), c);
        check({tag, "_round"}, int'(round_ctr), r);
        check({tag, "_sd"}, int'(sudden_death), sd);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        check_all("reset", START, 0, 0, 0, 0);
        check("reset_mode", int'(game_mode), SOLO);

        // Start in MULTI; held button yields no second edge
        mode_multi = 1'b1;
        start_btn  = 1'b1;
        tick();
        check("start_state", int'(game_state), SHOOTER);
        check("start_mode", int'(game_mode), MULTI);
        tick();
        check("held_btn_state", int'(game_state), SHOOTER);
        start_btn = 1'b0;
        tick();

        // Reach 2:1 then reset mid-game with a shot pending
        shot(1'b1);
        check("p1_state", int'(game_state), KEEPER);
        shot(1'b1);
        shot(1'b1);
        shot(1'b0);
        check_all("pre_rst", SHOOTER, 2, 1, 2, 0);
        rst = 1'b1; shot_valid = 1'b1; shot_goal = 1'b1;
        tick();
        rst = 1'b0; shot_valid = 1'b0; shot_goal = 1'b0;
        check_all("mid_rst", START, 0, 0, 0, 0);
        check("mid_rst_mode", int'(game_mode), SOLO);

        // Solo game; start edge in SHOOTER ignored
        mode_multi = 1'b0;
        start_btn  = 1'b1;
        tick();
        check("solo_mode", int'(game_mode), SOLO);
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        check("btn_in_shooter", int'(game_state), SHOOTER);
        start_btn = 1'b0;

        // Player scores 3, cpu misses 3: WINNER only after 6th pulse
        shot(1'b1); shot(1'b0); shot(1'b1); shot(1'b0); shot(1'b1);
        check_all("five_shots", KEEPER, 3, 0, 2, 0);
        shot(1'b0);
        check_all("early_win", WINNER, 3, 0, 3, 0);
        shot(1'b1);
        check_all("shot_in_winner", WINNER, 3, 0, 3, 0);

        // Hold: early start edge ignored, later one accepted; scores kept
        for (int i = 0; i < 8; i++) tick();
        start_btn = 1'b1;
        tick();
        check("early_restart", int'(game_state), WINNER);
        start_btn = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        start_btn = 1'b1;
        tick();
        check_all("restart", START, 3, 0, 3, 0);
        start_btn = 1'b0;
        tick();

        // Level 3:3 after regulation enters sudden death
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check_all("new_game", SHOOTER, 0, 0, 0, 0);
        for (int pr = 0; pr < 5; pr++) begin
            shot(pr % 2 == 0);
            shot(pr % 2 == 0);
            if (pr == 3) check_all("pair4", SHOOTER, 2, 2, 4, 0);
        end
        check_all("level", SHOOTER, 3, 3, 5, 1);

        // Sudden death: no decision after the shooter's goal alone
        shot(1'b1);
        check_all("sd_shooter", KEEPER, 4, 3, 5, 1);
        shot(1'b0);
        check_all("sd_win", WINNER, 4, 3, 6, 1);

        // Cpu pulls away: LOOSER after 6th pulse
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        shot(1'b0); shot(1'b1); shot(1'b0); shot(1'b1); shot(1'b0);
        check_all("lose5", KEEPER, 0, 2, 2, 0);
        shot(1'b1);
        check_all("lose6", LOOSER, 0, 3, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
